// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and ALU control constants for the op sequencer
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_INC = 4'h8,
        OP_DEC = 4'h9,
        OP_OUT = 4'hA
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       m;
        logic       cn;
    } alu_ctrl_t;

    // Logic-mode ops ignore carry-in; cn is parked at 1 (no carry) for them.
    localparam alu_ctrl_t CTRL_IDLE = '{sel: 4'b0000, m: 1'b1, cn: 1'b1};
    localparam alu_ctrl_t CTRL_ADD  = '{sel: 4'b1001, m: 1'b0, cn: 1'b1};
    localparam alu_ctrl_t CTRL_SUB  = '{sel: 4'b0110, m: 1'b0, cn: 1'b0};
    localparam alu_ctrl_t CTRL_AND  = '{sel: 4'b1011, m: 1'b1, cn: 1'b1};
    localparam alu_ctrl_t CTRL_OR   = '{sel: 4'b1110, m: 1'b1, cn: 1'b1};
    localparam alu_ctrl_t CTRL_XOR  = '{sel: 4'b0110, m: 1'b1, cn: 1'b1};
    localparam alu_ctrl_t CTRL_NOT  = '{sel: 4'b0000, m: 1'b1, cn: 1'b1};
    localparam alu_ctrl_t CTRL_INC  = '{sel: 4'b0000, m: 1'b0, cn: 1'b0};
    localparam alu_ctrl_t CTRL_DEC  = '{sel: 4'b1111, m: 1'b0, cn: 1'b1};

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode decoder
//
// Ports:
//   op     in  4  opcode
//   ctrl   out    ALU control {sel, m, cn} for the opcode (idle values otherwise)
//   is_alu out 1  opcode executes on the ALU (ADD..DEC)
//   legal  out 1  opcode is defined (0x0..0xA)
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    output alu_ctrl_t  ctrl,
    output logic       is_alu,
    output logic       legal
);

    always_comb begin
        ctrl   = CTRL_IDLE;
        is_alu = 1'b0;
        legal  = 1'b1;
        case (op)
            OP_NOP, OP_LDI, OP_OUT: ;
            OP_ADD: begin ctrl = CTRL_ADD; is_alu = 1'b1; end
            OP_SUB: begin ctrl = CTRL_SUB; is_alu = 1'b1; end
            OP_AND: begin ctrl = CTRL_AND; is_alu = 1'b1; end
            OP_OR:  begin ctrl = CTRL_OR;  is_alu = 1'b1; end
            OP_XOR: begin ctrl = CTRL_XOR; is_alu = 1'b1; end
            OP_NOT: begin ctrl = CTRL_NOT; is_alu = 1'b1; end
            OP_INC: begin ctrl = CTRL_INC; is_alu = 1'b1; end
            OP_DEC: begin ctrl = CTRL_DEC; is_alu = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - single-issue sequencer driving an external 4-bit ALU
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   instr_valid/ready      instruction handshake; instr_op opcode, instr_imm immediate
//   alu_sel/m/cn/a/b       registered controls and operands to the external ALU
//   alu_f                  combinational ALU result
//   acc, zero              accumulator and its zero flag
//   res_valid/ready/data   result handshake for the OUT instruction
//   err                    sticky illegal-opcode flag
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [3:0] instr_imm,
    output logic [3:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_m,
    output logic       alu_cn,
    input  logic [3:0] alu_f,
    output logic [3:0] acc,
    output logic       zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       err
);

    // Counter runs EXEC_CYCLES-1 .. 0; the edge that sees 0 captures alu_f.
    localparam logic [2:0] CNT_LOAD = 3'(EXEC_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;

    alu_ctrl_t dec_ctrl;
    logic      dec_is_alu;
    logic      dec_legal;

    alu_op_decode u_decode (
        .op     (instr_op),
        .ctrl   (dec_ctrl),
        .is_alu (dec_is_alu),
        .legal  (dec_legal)
    );

    assign instr_ready = rst_n && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            acc       <= 4'h0;
            zero      <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 4'h0;
            err       <= 1'b0;
            alu_sel   <= CTRL_IDLE.sel;
            alu_m     <= CTRL_IDLE.m;
            alu_cn    <= CTRL_IDLE.cn;
            alu_a     <= 4'h0;
            alu_b     <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (!dec_legal) begin
                            err <= 1'b1;
                        end else if (dec_is_alu) begin
                            state   <= ST_EXEC;
                            cnt     <= CNT_LOAD;
                            alu_sel <= dec_ctrl.sel;
                            alu_m   <= dec_ctrl.m;
                            alu_cn  <= dec_ctrl.cn;
                            alu_a   <= acc;
                            alu_b   <= instr_imm;
                        end else if (instr_op == OP_LDI) begin
                            acc   <= instr_imm;
                            zero  <= (instr_imm == 4'h0);
                            // alu_a mirrors acc whenever the ALU is idle
                            alu_a <= instr_imm;
                        end else if (instr_op == OP_OUT) begin
                            state     <= ST_OUT;
                            res_valid <= 1'b1;
                            res_data  <= acc;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == 3'd0) begin
                        acc     <= alu_f;
                        zero    <= (alu_f == 4'h0);
                        state   <= ST_IDLE;
                        alu_sel <= CTRL_IDLE.sel;
                        alu_m   <= CTRL_IDLE.m;
                        alu_cn  <= CTRL_IDLE.cn;
                        alu_a   <= alu_f;
                        alu_b   <= 4'h0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 uses EXEC_CYCLES=1, instance 1 uses EXEC_CYCLES=3.
    int         ec [2];
    logic       rst_n [2];
    logic       instr_valid [2];
    logic       instr_ready [2];
    logic [3:0] instr_op [2];
    logic [3:0] instr_imm [2];
    logic [3:0] alu_sel [2];
    logic [3:0] alu_a [2];
    logic [3:0] alu_b [2];
    logic       alu_m [2];
    logic       alu_cn [2];
    logic [3:0] alu_f [2];
    logic [3:0] acc [2];
    logic       zero [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [3:0] res_data [2];
    logic       err [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_acc [2];
    logic       m_err [2];

    // Behaviour of a 74181-style ALU for the function codes in use.
    function automatic logic [3:0] alu_chip(logic [3:0] s, logic m, logic cn,
                                            logic [3:0] a, logic [3:0] b);
        logic [3:0] c;
        c = {3'b000, ~cn};
        case ({m, s})
            5'b0_1001: return a + b + c;
            5'b0_0110: return a - b - 4'h1 + c;
            5'b0_0000: return a + c;
            5'b0_1111: return a - 4'h1 + c;
            5'b1_1011: return a & b;
            5'b1_1110: return a | b;
            5'b1_0110: return a ^ b;
            5'b1_0000: return ~a;
            default:   return a ^ 4'h5;
        endcase
    endfunction

    assign alu_f[0] = alu_chip(alu_sel[0], alu_m[0], alu_cn[0], alu_a[0], alu_b[0]);
    assign alu_f[1] = alu_chip(alu_sel[1], alu_m[1], alu_cn[1], alu_a[1], alu_b[1]);

    alu_op_sequencer #(.EXEC_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
        .instr_op(instr_op[0]), .instr_imm(instr_imm[0]), .alu_sel(alu_sel[0]), .alu_a(alu_a[0]),
        .alu_b(alu_b[0]), .alu_m(alu_m[0]), .alu_cn(alu_cn[0]), .alu_f(alu_f[0]), .acc(acc[0]),
        .zero(zero[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .err(err[0])
    );

    alu_op_sequencer #(.EXEC_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
        .instr_op(instr_op[1]), .instr_imm(instr_imm[1]), .alu_sel(alu_sel[1]), .alu_a(alu_a[1]),
        .alu_b(alu_b[1]), .alu_m(alu_m[1]), .alu_cn(alu_cn[1]), .alu_f(alu_f[1]), .acc(acc[1]),
        .zero(zero[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected accumulator result straight from the instruction semantics.
    function automatic logic [3:0] ref_result(int op, logic [3:0] a, logic [3:0] b);
        case (op)
            2: return 4'((int'(a) + int'(b)) % 16);
            3: return 4'((int'(a) - int'(b) + 16) % 16);
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            7: return 4'(15 - int'(a));
            8: return 4'((int'(a) + 1) % 16);
            9: return 4'((int'(a) + 15) % 16);
            default: return a;
        endcase
    endfunction

    // Documented {sel, m, cn} for each ALU opcode.
    function automatic logic [5:0] ref_ctrl(int op);
        case (op)
            2: return 6'b1001_0_1;
            3: return 6'b0110_0_0;
            4: return 6'b1011_1_1;
            5: return 6'b1110_1_1;
            6: return 6'b0110_1_1;
            7: return 6'b0000_1_1;
            8: return 6'b0000_0_0;
            9: return 6'b1111_0_1;
            default: return 6'b0000_1_1;
        endcase
    endfunction

    task automatic noise(input int u);
        instr_valid[u] = 1'($urandom_range(0, 1));
        instr_op[u]    = 4'($urandom_range(0, 15));
        instr_imm[u]   = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        rst_n[u] = 1'b0;
        instr_valid[u] = 1'b1;
        instr_op[u] = 4'h1;
        instr_imm[u] = 4'h7;
        res_ready[u] = 1'b0;
        @(posedge clk); #1;
        check("ready_in_reset", instr_ready[u], 1'b0);
        check("rst_acc", acc[u], 4'h0);
        check("rst_zero", zero[u], 1'b1);
        check("rst_res_valid", res_valid[u], 1'b0);
        check("rst_res_data", res_data[u], 4'h0);
        check("rst_err", err[u], 1'b0);
        check("rst_alu_ctrl", {alu_sel[u], alu_m[u], alu_cn[u]}, 6'b0000_1_1);
        check("rst_alu_ab", {alu_a[u], alu_b[u]}, 8'h00);
        @(negedge clk);
        rst_n[u] = 1'b1;
        instr_valid[u] = 1'b0;
        #1;
        check("ready_after_reset", instr_ready[u], 1'b1);
        m_acc[u] = 4'h0;
        m_err[u] = 1'b0;
    endtask

    task automatic issue(input int u, input int op, input logic [3:0] imm, input int hold);
        logic [3:0] exp;
        @(negedge clk);
        check("ready_before_issue", instr_ready[u], 1'b1);
        instr_valid[u] = 1'b1;
        instr_op[u]    = 4'(op);
        instr_imm[u]   = imm;
        @(posedge clk); #1;
        instr_valid[u] = 1'b0;
        if (op >= 2 && op <= 9) begin
            exp = ref_result(op, m_acc[u], imm);
            check("exec_sel_m", {alu_sel[u], alu_m[u]}, ref_ctrl(op) >> 1);
            if (ref_ctrl(op) & 6'b000010) begin
            end else begin
                check("exec_cn", alu_cn[u], ref_ctrl(op) & 6'b1);
            end
            check("exec_a", alu_a[u], m_acc[u]);
            check("exec_b", alu_b[u], imm);
            check("exec_ready", instr_ready[u], 1'b0);
            for (int k = 1; k < ec[u]; k++) begin
                @(negedge clk);
                noise(u);
                @(posedge clk); #1;
                check("exec_acc_held", acc[u], m_acc[u]);
                check("exec_ready_held", instr_ready[u], 1'b0);
                check("exec_ctrl_held", {alu_sel[u], alu_m[u], alu_b[u]},
                      {ref_ctrl(op) >> 1, imm});
            end
            @(negedge clk);
            noise(u);
            @(posedge clk); #1;
            instr_valid[u] = 1'b0;
            m_acc[u] = exp;
            check("exec_result", acc[u], exp);
            check("exec_zero", zero[u], exp == 4'h0);
            check("post_exec_ready", instr_ready[u], 1'b1);
            check("post_exec_idle_ctrl", {alu_sel[u], alu_m[u], alu_cn[u]}, 6'b0000_1_1);
            check("post_exec_idle_ab", {alu_a[u], alu_b[u]}, {exp, 4'h0});
        end else if (op == 1) begin
            m_acc[u] = imm;
            check("ldi_acc", acc[u], imm);
            check("ldi_zero", zero[u], imm == 4'h0);
            check("ldi_alu_a", alu_a[u], imm);
        end else if (op == 0) begin
            check("nop_acc", acc[u], m_acc[u]);
        end else if (op == 10) begin
            check("out_valid", res_valid[u], 1'b1);
            check("out_data", res_data[u], m_acc[u]);
            check("out_ready", instr_ready[u], 1'b0);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                noise(u);
                @(posedge clk); #1;
                check("out_hold_valid", res_valid[u], 1'b1);
                check("out_hold_data", res_data[u], m_acc[u]);
            end
            @(negedge clk);
            instr_valid[u] = 1'b0;
            res_ready[u] = 1'b1;
            @(posedge clk); #1;
            res_ready[u] = 1'b0;
            check("out_done_valid", res_valid[u], 1'b0);
            check("out_done_ready", instr_ready[u], 1'b1);
        end else begin
            m_err[u] = 1'b1;
            check("illegal_acc", acc[u], m_acc[u]);
        end
        check("err_flag", err[u], m_err[u]);
        check("acc_track", acc[u], m_acc[u]);
    endtask

    initial begin
        ec[0] = 1;
        ec[1] = 3;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            instr_valid[u] = 1'b0;
            instr_op[u] = 4'h0;
            instr_imm[u] = 4'h0;
            res_ready[u] = 1'b0;
        end

        for (int u = 0; u < 2; u++) begin
            do_reset(u);
            issue(u, 1, 4'h4, 0);
            issue(u, 2, 4'h3, 0);          // 4 + 3 = 7
            issue(u, 1, 4'h4, 0);
            issue(u, 3, 4'h4, 0);          // 4 - 4 = 0, zero set
            issue(u, 9, 4'h0, 0);          // 0 - 1 wraps to F
            issue(u, 1, 4'h5, 0);
            issue(u, 6, 4'hA, 0);          // 5 ^ A = F
            issue(u, 1, 4'h9, 0);
            issue(u, 10, 4'h0, 4);         // OUT held four cycles
            issue(u, 12, 4'h3, 0);         // illegal, err set
            issue(u, 0, 4'h8, 0);
            issue(u, 8, 4'h0, 0);
        end

        // Reset mid-EXEC abandons the operation.
        issue(1, 1, 4'h6, 0);
        @(negedge clk);
        instr_valid[1] = 1'b1;
        instr_op[1] = 4'h2;
        instr_imm[1] = 4'h5;
        @(posedge clk); #1;
        instr_valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        check("midexec_rst_acc", acc[1], 4'h0);
        check("midexec_rst_err", err[1], 1'b0);
        check("midexec_rst_ready", instr_ready[1], 1'b0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        check("midexec_after_acc", acc[1], 4'h0);
        check("midexec_after_ready", instr_ready[1], 1'b1);
        m_acc[1] = 4'h0;
        m_err[1] = 1'b0;

        // Reset mid-OUT drops res_valid without a transfer.
        issue(1, 1, 4'hC, 0);
        @(negedge clk);
        instr_valid[1] = 1'b1;
        instr_op[1] = 4'hA;
        @(posedge clk); #1;
        instr_valid[1] = 1'b0;
        check("midout_valid", res_valid[1], 1'b1);
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        check("midout_rst_valid", res_valid[1], 1'b0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        m_acc[1] = 4'h0;
        m_err[1] = 1'b0;

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 80; n++) begin
                issue(u, $urandom_range(0, 15), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter EXEC_CYCLES, default 1: cycles the ALU controls are held before the result is captured; legal range 1..8.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 instr_valid  in  1  an instruction is offered.
REQ-005 instr_ready  out  1  the block can accept an instruction.
REQ-006 instr_op  in  4  opcode.
REQ-007 instr_imm  in  4  immediate operand, used as B or as the load value.
REQ-008 alu_sel  out  4  ALU function select.
REQ-009 alu_a  out  4  ALU A operand.
REQ-010 alu_b  out  4  ALU B operand.
REQ-011 alu_m  out  1  ALU mode: 1 = logic, 0 = arithmetic.
REQ-012 alu_cn  out  1  ALU carry-in, active-low (0 = carry in).
REQ-013 alu_f  in  4  combinational ALU result.
REQ-014 acc  out  4  accumulator.
REQ-015 zero  out  1  acc == 0.
REQ-016 res_valid  out  1  res_data is valid.
REQ-017 res_ready  in  1  the consumer accepts res_data.
REQ-018 res_data  out  4  output value.
REQ-019 err  out  1  sticky flag: an illegal opcode was accepted.

Function
REQ-020 An instruction SHALL be accepted on a rising edge where instr_valid && instr_ready; instr_ready SHALL be 1 only in IDLE with rst_n=1.
REQ-021 FSM states SHALL be IDLE, EXEC, OUT; transitions:
- IDLE -> EXEC on accepting an ALU opcode.
- IDLE -> OUT on accepting OUT.
- IDLE stays IDLE on accepting NOP, LDI or an illegal opcode.
REQ-022 The opcode map SHALL be (sel/M/Cn):
- 0x0 NOP.
- 0x1 LDI.
- 0x2 ADD: 1001/0/1.
- 0x3 SUB: 0110/0/0.
- 0x4 AND: 1011/1/x.
- 0x5 OR: 1110/1/x.
- 0x6 XOR: 0110/1/x.
- 0x7 NOT: 0000/1/x.
- 0x8 INC: 0000/0/0.
- 0x9 DEC: 1111/0/1.
- 0xA OUT.
- 0xB-0xF illegal.
REQ-023 On the accepting edge, alu_sel/alu_m/alu_cn SHALL be registered from the opcode, alu_a from acc and alu_b from instr_imm; they SHALL be held constant throughout EXEC.
REQ-024 A down-counter SHALL hold EXEC for exactly EXEC_CYCLES cycles; on the final EXEC edge acc SHALL be loaded with alu_f and the state SHALL return to IDLE.
REQ-025 Timing for ALU opcodes: accept at edge t0, acc valid after edge t0+EXEC_CYCLES, next accept no earlier than edge t0+EXEC_CYCLES+1.
REQ-026 LDI SHALL load acc with instr_imm on the accepting edge; NOP SHALL change nothing; an illegal opcode SHALL set err and leave acc unchanged.
REQ-027 Outside EXEC, ALU outputs SHALL idle at sel=0000, m=1, cn=1, a=acc, b=0.
REQ-028 On entering OUT, res_data SHALL be registered from acc and res_valid SHALL be 1.
REQ-029 While in OUT, res_valid and res_data SHALL hold until an edge with res_ready=1, after which the state SHALL be IDLE and res_valid 0.
REQ-030 zero SHALL be registered together with every acc update.
REQ-031 Arithmetic SHALL wrap mod 16 and no carry-out SHALL be tracked.
REQ-032 instr_valid SHALL be ignored outside IDLE: no queueing.

Reset
REQ-033 While rst_n=0 at an edge, the block SHALL load:
- state = IDLE
- acc = 0, zero = 1
- res_valid = 0, res_data = 0
- err = 0
- counter = 0
- ALU outputs at their idle values.
REQ-034 While rst_n=0, instr_ready SHALL be 0.
REQ-035 Reset asserted in EXEC or OUT SHALL abandon the operation with no acc write and no handshake completion.

Structure
REQ-036 Package alu_seq_pkg SHALL hold the opcode enum, the state enum, the ALU-control struct {sel,m,cn} and the per-opcode control constants.
REQ-037 Opcode decode SHALL be the combinational sub-module alu_op_decode (op -> ctrl, is_alu, legal).

Verification
REQ-038 Reset, then LDI 4, then ADD 3 -> alu_sel=1001, m=0, cn=1, alu_a=4, alu_b=3; acc=7 after 1 EXEC cycle; zero=0.
REQ-039 acc=4, SUB 4 -> acc=0, zero=1; then DEC -> acc=F (wrap).
REQ-040 EXEC_CYCLES=3, acc=5, XOR A -> acc=F after exactly 3 EXEC cycles; instr_ready=0 throughout EXEC.
REQ-041 acc=9, OUT with res_ready=0 for 4 cycles -> res_valid=1, res_data=9 held; res_ready=1 -> one transfer, back to IDLE.
REQ-042 Opcode 0xC -> err=1, acc unchanged; rst_n=0 asserted mid-EXEC -> acc=0, err=0, state IDLE.
